// File: rtl/lime_pkg.sv
// lime_pkg: shared opcode/funct constants, branch condition encoding and
// default widths for the multi-cycle datapath slice.
`default_nettype none

package lime_pkg;

    localparam int DW_DEFAULT  = 16;
    localparam int RAW_DEFAULT = 3;

    localparam logic [2:0] OP_3R  = 3'b000;
    localparam logic [2:0] OP_2RI = 3'b001;
    localparam logic [2:0] OP_RI  = 3'b010;
    localparam logic [2:0] OP_L   = 3'b011;
    localparam logic [2:0] OP_UJ  = 3'b100;

    localparam logic [3:0] FN_LW   = 4'b1001;
    localparam logic [3:0] FN_SW   = 4'b1010;
    localparam logic [3:0] FN_JALR = 4'b1011;

    typedef enum logic [1:0] {
        BEQ = 2'b00,
        BNE = 2'b01,
        BLT = 2'b10,
        BGE = 2'b11
    } branch_type_t;

    // Opcodes above OP_UJ are unassigned.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op > OP_UJ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate extractor selected by the instruction format.
`default_nettype none

module imm_gen
    import lime_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] ir,
    output logic [DW-1:0] imm
);

    logic [2:0] w_opcode;
    assign w_opcode = ir[2:0];

    always_comb begin
        imm = '0;
        case (w_opcode)
            OP_2RI:  imm = {{(DW-3){ir[15]}}, ir[15:13]};
            OP_RI:   imm = {{(DW-6){ir[15]}}, ir[15:10]};
            OP_L:    imm = {{(DW-9){1'b0}},   ir[15:7]};
            OP_UJ:   imm = {{(DW-10){ir[15]}}, ir[15:6]};
            default: imm = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ir_decode_latch.sv
// ir_decode_latch: IR/MDR/A/B/ALUOut latches, IR field decode and branch-qualified
// PC write. Optional sticky illegal-opcode flag under ILLEGAL_OPCODE_TRAP_EN.
`default_nettype none

module ir_decode_latch
    import lime_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int RAW = RAW_DEFAULT
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [DW-1:0]  mem_rdata,
    input  logic [DW-1:0]  rf_rdata1,
    input  logic [DW-1:0]  rf_rdata2,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_zero,
    input  logic           alu_neg,
    input  logic           IRWrite,
    input  logic           MemR,
    input  logic           keepALUOut,
    input  logic           Branch,
    input  logic [1:0]     BranchType,
    input  logic           PCWrite,
    output logic [6:0]     input_control,
    output logic [RAW-1:0] rs1_addr,
    output logic [RAW-1:0] rs2_addr,
    output logic [RAW-1:0] rd_addr,
    output logic [DW-1:0]  imm_ext,
    output logic [DW-1:0]  ir_q,
    output logic [DW-1:0]  mdr_q,
    output logic [DW-1:0]  a_q,
    output logic [DW-1:0]  b_q,
    output logic [DW-1:0]  aluout_q,
    output logic           pc_we,
    output logic           illegal
);

    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_mdr;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_aluout;
    logic [2:0]    w_opcode;
    logic          w_taken;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            if (IRWrite)
                r_ir <= mem_rdata;
            if (MemR)
                r_mdr <= mem_rdata;
            r_a <= rf_rdata1;
            r_b <= rf_rdata2;
            if (!keepALUOut)
                r_aluout <= alu_result;
        end
    end

    assign ir_q     = r_ir;
    assign mdr_q    = r_mdr;
    assign a_q      = r_a;
    assign b_q      = r_b;
    assign aluout_q = r_aluout;

    assign w_opcode      = r_ir[2:0];
    assign input_control = r_ir[6:0];

    // Default field positions are the 3R layout; other formats override.
    always_comb begin
        rd_addr  = RAW'(r_ir[9:7]);
        rs1_addr = RAW'(r_ir[12:10]);
        rs2_addr = RAW'(r_ir[15:13]);
        case (w_opcode)
            OP_RI:   rs1_addr = RAW'(r_ir[9:7]);
            OP_L:    rd_addr  = '0;
            OP_UJ:   rd_addr  = RAW'(r_ir[5:3]);
            default: ;
        endcase
    end

    imm_gen #(
        .DW (DW)
    ) u_imm_gen (
        .ir  (r_ir),
        .imm (imm_ext)
    );

    always_comb begin
        w_taken = 1'b0;
        case (branch_type_t'(BranchType))
            BEQ: w_taken = alu_zero;
            BNE: w_taken = ~alu_zero;
            BLT: w_taken = alu_neg;
            BGE: w_taken = ~alu_neg;
            default: w_taken = 1'b0;
        endcase
    end

    assign pc_we = PCWrite & (~Branch | w_taken);

`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic r_illegal;

    // Flags on the load edge itself so it becomes visible together with the new IR.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            r_illegal <= 1'b0;
        else if (IRWrite && is_illegal_op(mem_rdata[2:0]))
            r_illegal <= 1'b1;
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ir_decode_latch.sv
// tb_ir_decode_latch: directed self-checking bench for ir_decode_latch.
`default_nettype none

module tb_ir_decode_latch;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] mem_rdata, rf_rdata1, rf_rdata2, alu_result;
    logic        alu_zero, alu_neg, IRWrite, MemR, keepALUOut, Branch, PCWrite;
    logic [1:0]  BranchType;
    logic [6:0]  input_control;
    logic [2:0]  rs1_addr, rs2_addr, rd_addr;
    logic [15:0] imm_ext, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic        pc_we, illegal;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    ir_decode_latch dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .mem_rdata     (mem_rdata),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .IRWrite       (IRWrite),
        .MemR          (MemR),
        .keepALUOut    (keepALUOut),
        .Branch        (Branch),
        .BranchType    (BranchType),
        .PCWrite       (PCWrite),
        .input_control (input_control),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .imm_ext       (imm_ext),
        .ir_q          (ir_q),
        .mdr_q         (mdr_q),
        .a_q           (a_q),
        .b_q           (b_q),
        .aluout_q      (aluout_q),
        .pc_we         (pc_we),
        .illegal       (illegal)
    );

    task automatic load_ir(input logic [15:0] v);
        @(negedge CLK);
        mem_rdata = v;
        IRWrite   = 1'b1;
        @(posedge CLK);
        #1;
        IRWrite   = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (ir_q !== 16'h0 || mdr_q !== 16'h0 || a_q !== 16'h0 || b_q !== 16'h0 || aluout_q !== 16'h0) begin
            failures++;
            $display("FAIL reset_regs: ir=%h mdr=%h a=%h b=%h alu=%h required all 0000", ir_q, mdr_q, a_q, b_q, aluout_q);
        end
        checks++;
        if (input_control !== 7'h00 || imm_ext !== 16'h0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_decode: ctl=%h imm=%h ill=%b required 00/0000/0", input_control, imm_ext, illegal);
        end
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        mem_rdata  = 16'hFFFF;
        IRWrite    = 1'b1;
        alu_result = 16'hAAAA;
        PCWrite    = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (ir_q !== 16'hFFFF || aluout_q !== 16'hAAAA) begin
            failures++;
            $display("FAIL preload: ir=%h alu=%h required ffff/aaaa", ir_q, aluout_q);
        end
        IRWrite = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        checks++;
        if (ir_q !== 16'h0 || aluout_q !== 16'h0 || pc_we !== 1'b0 || input_control !== 7'h00) begin
            failures++;
            $display("FAIL async_reset: ir=%h alu=%h pc_we=%b ctl=%h required 0000/0000/0/00", ir_q, aluout_q, pc_we, input_control);
        end
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic test_decode_3r;
        load_ir(16'b101_010_011_0001_000);
        checks++;
        if (input_control !== 7'b0001000 || rd_addr !== 3'd3 || rs1_addr !== 3'd2 || rs2_addr !== 3'd5 || imm_ext !== 16'h0) begin
            failures++;
            $display("FAIL decode_3r: ctl=%b rd=%0d rs1=%0d rs2=%0d imm=%h required 0001000/3/2/5/0000",
                     input_control, rd_addr, rs1_addr, rs2_addr, imm_ext);
        end
        @(negedge CLK);
        mem_rdata = 16'h0000;
        @(posedge CLK);
        #1;
        checks++;
        if (ir_q !== 16'b101_010_011_0001_000) begin
            failures++;
            $display("FAIL ir_hold: ir=%h required a988", ir_q);
        end
    endtask

    task automatic test_imm;
        load_ir(16'b111110_101_0000_010);
        checks++;
        if (imm_ext !== 16'hFFFE || rd_addr !== 3'd5 || rs1_addr !== 3'd5) begin
            failures++;
            $display("FAIL imm_ri: imm=%h rd=%0d rs1=%0d required fffe/5/5", imm_ext, rd_addr, rs1_addr);
        end
        load_ir(16'b100_001_010_0000_001);
        checks++;
        if (imm_ext !== 16'hFFFC || rd_addr !== 3'd2 || rs1_addr !== 3'd1) begin
            failures++;
            $display("FAIL imm_2ri: imm=%h rd=%0d rs1=%0d required fffc/2/1", imm_ext, rd_addr, rs1_addr);
        end
        load_ir(16'b111111111_0000_011);
        checks++;
        if (imm_ext !== 16'h01FF || rd_addr !== 3'd0) begin
            failures++;
            $display("FAIL imm_l: imm=%h rd=%0d required 01ff/0", imm_ext, rd_addr);
        end
        load_ir(16'h801C);
        checks++;
        if (imm_ext !== 16'hFE00 || rd_addr !== 3'd3) begin
            failures++;
            $display("FAIL imm_uj: imm=%h rd=%0d required fe00/3", imm_ext, rd_addr);
        end
        load_ir(16'hFFFD);
        checks++;
        if (imm_ext !== 16'h0 || rd_addr !== 3'd7 || input_control !== 7'h7D) begin
            failures++;
            $display("FAIL imm_op101: imm=%h rd=%0d ctl=%h required 0000/7/7d", imm_ext, rd_addr, input_control);
        end
    endtask

    task automatic test_branch;
        logic [5:0] vec [8];
        logic       exp [8];
        // {PCWrite, Branch, BranchType, alu_zero, alu_neg}
        vec[0] = 6'b11_00_1_0; exp[0] = 1'b1;
        vec[1] = 6'b11_00_0_0; exp[1] = 1'b0;
        vec[2] = 6'b11_11_0_0; exp[2] = 1'b1;
        vec[3] = 6'b11_11_0_1; exp[3] = 1'b0;
        vec[4] = 6'b01_00_1_1; exp[4] = 1'b0;
        vec[5] = 6'b11_01_0_0; exp[5] = 1'b1;
        vec[6] = 6'b11_10_1_1; exp[6] = 1'b1;
        vec[7] = 6'b10_10_0_0; exp[7] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {PCWrite, Branch, BranchType, alu_zero, alu_neg} = vec[i];
            #1;
            checks++;
            if (pc_we !== exp[i]) begin
                failures++;
                $display("FAIL branch[%0d]: pc_we=%b required %b", i, pc_we, exp[i]);
            end
        end
        PCWrite = 1'b0;
        Branch  = 1'b0;
    endtask

    task automatic test_aluout;
        @(negedge CLK);
        alu_result = 16'h1234; keepALUOut = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (aluout_q !== 16'h1234) begin
            failures++;
            $display("FAIL aluout_load: got=%h required 1234", aluout_q);
        end
        @(negedge CLK);
        alu_result = 16'h5678; keepALUOut = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (aluout_q !== 16'h1234) begin
            failures++;
            $display("FAIL aluout_keep: got=%h required 1234", aluout_q);
        end
        @(negedge CLK);
        keepALUOut = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (aluout_q !== 16'h5678) begin
            failures++;
            $display("FAIL aluout_resume: got=%h required 5678", aluout_q);
        end
    endtask

    task automatic test_ab_mdr;
        @(negedge CLK);
        rf_rdata1 = 16'h1111; rf_rdata2 = 16'h2222; mem_rdata = 16'h3333; MemR = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (a_q !== 16'h1111 || b_q !== 16'h2222 || mdr_q !== 16'h3333) begin
            failures++;
            $display("FAIL ab_mdr_load: a=%h b=%h mdr=%h required 1111/2222/3333", a_q, b_q, mdr_q);
        end
        @(negedge CLK);
        rf_rdata1 = 16'hABCD; rf_rdata2 = 16'h0F0F; mem_rdata = 16'h4444; MemR = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (a_q !== 16'hABCD || b_q !== 16'h0F0F || mdr_q !== 16'h3333 || ir_q !== 16'hFFFD) begin
            failures++;
            $display("FAIL ab_mdr_hold: a=%h b=%h mdr=%h ir=%h required abcd/0f0f/3333/fffd", a_q, b_q, mdr_q, ir_q);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge CLK);
        mem_rdata = 16'h2C4A; IRWrite = 1'b1; MemR = 1'b1;
        @(posedge CLK);
        #1;
        IRWrite = 1'b0; MemR = 1'b0;
        checks++;
        if (ir_q !== 16'h2C4A || mdr_q !== 16'h2C4A) begin
            failures++;
            $display("FAIL ir_mdr_same: ir=%h mdr=%h required 2c4a/2c4a", ir_q, mdr_q);
        end
        load_ir(16'h0001);
        checks++;
        if (ir_q !== 16'h0001 || mdr_q !== 16'h2C4A) begin
            failures++;
            $display("FAIL ir_only: ir=%h mdr=%h required 0001/2c4a", ir_q, mdr_q);
        end
    endtask

    task automatic test_illegal;
`ifdef ILLEGAL_OPCODE_TRAP_EN
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        load_ir(16'h0002);
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_legal: got=%b required 0", illegal);
        end
        load_ir(16'h0006);
        checks++;
        if (illegal !== 1'b1 || ir_q !== 16'h0006) begin
            failures++;
            $display("FAIL illegal_set: ill=%b ir=%h required 1/0006", illegal, ir_q);
        end
        load_ir(16'h0003);
        checks++;
        if (illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_sticky: got=%b required 1", illegal);
        end
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear: got=%b required 0", illegal);
        end
        Reset = 1'b0;
`else
        load_ir(16'h0006);
        checks++;
        if (illegal !== 1'b0 || ir_q !== 16'h0006) begin
            failures++;
            $display("FAIL illegal_tied: ill=%b ir=%h required 0/0006", illegal, ir_q);
        end
`endif
    endtask

    initial begin
        Reset = 1'b1;
        mem_rdata = '0; rf_rdata1 = '0; rf_rdata2 = '0; alu_result = '0;
        alu_zero = 1'b0; alu_neg = 1'b0; IRWrite = 1'b0; MemR = 1'b0;
        keepALUOut = 1'b0; Branch = 1'b0; BranchType = 2'b00; PCWrite = 1'b0;

        test_reset;
        test_decode_3r;
        test_imm;
        test_branch;
        test_aluout;
        test_ab_mdr;
        test_back_to_back;
        test_illegal;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ir_decode_latch.md
Name: ir_decode_latch

Overview:
- Multi-cycle datapath register stage that holds the architectural latches around the Control FSM.
- Owns the Instruction Register (IR), Memory Data Register (MDR), operand registers A/B and ALUOut.
- Decodes IR into the 7-bit control field, register addresses and a sign-extended immediate.
- Resolves conditional PC write: raw PCWrite/Branch/BranchType come in from Control; a qualified PC-write enable goes out.

Parameters:
- DW, 16, datapath and instruction width.
- RAW, 3, register address width (8 registers).

Ports:
- CLK  in  1  clock
- Reset  in  1  async active-high reset
- mem_rdata  in  DW  memory read data
- rf_rdata1  in  DW  register file port 1 read data
- rf_rdata2  in  DW  register file port 2 read data
- alu_result  in  DW  ALU combinational result
- alu_zero  in  1  ALU result == 0
- alu_neg  in  1  ALU result bit DW-1
- IRWrite  in  1  load IR from mem_rdata
- MemR  in  1  load MDR from mem_rdata
- keepALUOut  in  1  hold ALUOut
- Branch  in  1  branch qualify
- BranchType  in  2  condition select
- PCWrite  in  1  raw PC write
- input_control  out  7  {IR[6:3] funct4, IR[2:0] opcode} to Control
- rs1_addr / rs2_addr / rd_addr  out  RAW each  decoded register fields
- imm_ext  out  DW  sign-extended immediate
- ir_q / mdr_q / a_q / b_q / aluout_q  out  DW each  latched values
- pc_we  out  1  qualified PC write enable
- illegal  out  1  sticky illegal-opcode flag (feature only; 0 otherwise)

Behaviour:
- Reset: asynchronous, active-high on Reset; clock CLK. All registers (IR, MDR, A, B, ALUOut, illegal) clear to 0. Consequently input_control=0 (3R add) and imm_ext=0 while Reset is held. Reset mid-instruction discards all latched state immediately.
- IR: ir_q <= mem_rdata on the CLK edge with IRWrite=1; otherwise holds. Decode reflects the new IR the cycle after FETCH, i.e. valid in DECODE.
- MDR: mdr_q <= mem_rdata when MemR=1; otherwise holds. LW2 consumes the value loaded in LW1.
- A/B: a_q <= rf_rdata1 and b_q <= rf_rdata2 every cycle (no enable), giving one-cycle latency from address to operand.
- ALUOut: aluout_q <= alu_result every cycle unless keepALUOut=1, in which case it holds.
- Instruction formats (bit 15 is MSB):
  - opcode 000, 3R: rd=[9:7], rs1=[12:10], rs2=[15:13]; imm_ext=0.
  - opcode 001, 2RI: rd=[9:7], rs1=[12:10]; imm3=[15:13] sign-extended.
  - opcode 010, RI: rd=rs1=[9:7]; imm6=[15:10] sign-extended.
  - opcode 011, L: imm9=[15:7] zero-extended; rd=0.
  - opcode 100, UJ: rd=[5:3]; imm10=[15:6] sign-extended.
  - opcodes 101/110/111: fields decoded as 3R; imm_ext=0.
- Decode outputs are purely combinational from ir_q.
- Branch resolution (combinational), taken by BranchType:
  - 00: alu_zero
  - 01: ~alu_zero
  - 10: alu_neg
  - 11: ~alu_neg
- pc_we = PCWrite & (~Branch | taken). Branch=1 with PCWrite=0 (RITYPE store case) yields pc_we=0 regardless of flags.
- Simultaneous IRWrite and MemR: both IR and MDR load the same mem_rdata.

Optional Feature:
- Macro ILLEGAL_OPCODE_TRAP_EN.
- Defined: on the first cycle after IR loads an opcode in {101,110,111}, illegal sets to 1. It stays set until Reset. IR loads are unaffected.
- Undefined: illegal is tied to 0 and has no register.

Decomposition:
- Package lime_pkg holds:
  - opcode constants OP_3R..OP_UJ
  - funct4 constants for lw (1001), sw (1010), jalr (1011)
  - BranchType enum BEQ/BNE/BLT/BGE
  - DW and RAW defaults
- One sub-module: imm_gen, a combinational format-driven immediate extractor.

Test Plan:
- Reset asserted mid-cycle with ir_q=16'hFFFF -> ir_q, aluout_q, pc_we all 0 immediately; input_control=7'h00.
- mem_rdata=16'b101_010_011_0001_000 with IRWrite=1 -> next cycle input_control=7'b0001000, rd=3, rs1=2, rs2=5, imm_ext=0.
- RI ir=16'b111110_101_0000_010 -> imm_ext=16'hFFFE, rd=rs1=5. 2RI imm3=100 -> imm_ext=16'hFFFC.
- Branch=1, PCWrite=1, BranchType=00: alu_zero=1 -> pc_we=1; alu_zero=0 -> pc_we=0. BranchType=11 with alu_neg=0 -> pc_we=1. Branch=1, PCWrite=0 -> pc_we=0.
- alu_result=16'h1234 with keepALUOut=0, then alu_result=16'h5678 with keepALUOut=1 -> aluout_q stays 16'h1234.
- ILLEGAL_OPCODE_TRAP_EN defined: IR load of opcode 110 -> illegal=1 next cycle and remains 1 after a legal IR load; clears only on Reset.
